// File: rtl/l1_mau_arb.sv
// Shares one MAU port between the L1 I-cache (read only) and L1 D-cache (read/write).
// Round-robin on ties by default; `L1_MAU_ARB_FIXED_PRIO_EN makes the D-side always win ties.
module l1_mau_arb #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_val,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_req_ack,
  output logic [LINE_W-1:0] i_ack_data,
  input  logic              d_req_val,
  input  logic              d_req_cop,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [LINE_W-1:0] d_req_wdata,
  output logic              d_req_ack,
  output logic [LINE_W-1:0] d_ack_data,
  output logic              mem_req_val,
  output logic              mem_req_cop,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_wdata,
  input  logic              mem_req_ack,
  input  logic [LINE_W-1:0] mem_ack_data
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t              r_state;
  logic                r_val;
  logic                r_cop;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_wdata;
  logic                w_grant_i;
  logic                w_grant_d;
  logic                w_ack_i;
  logic                w_ack_d;

`ifdef L1_MAU_ARB_FIXED_PRIO_EN
  assign w_grant_d = (r_state == IDLE) && d_req_val;
  assign w_grant_i = (r_state == IDLE) && i_req_val && !d_req_val;
`else
  // r_last_d resets to 1 so the I-side wins the first tie
  logic r_last_d;
  assign w_grant_i = (r_state == IDLE) && i_req_val && (!d_req_val || r_last_d);
  assign w_grant_d = (r_state == IDLE) && d_req_val && (!i_req_val || !r_last_d);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_val    <= 1'b0;
      r_cop    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
`ifndef L1_MAU_ARB_FIXED_PRIO_EN
      r_last_d <= 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_i) begin
            r_state  <= BUSY_I;
            r_val    <= 1'b1;
            r_cop    <= 1'b0;
            r_addr   <= i_req_addr;
            r_wdata  <= '0;
`ifndef L1_MAU_ARB_FIXED_PRIO_EN
            r_last_d <= 1'b0;
`endif
          end else if (w_grant_d) begin
            r_state  <= BUSY_D;
            r_val    <= 1'b1;
            r_cop    <= d_req_cop;
            r_addr   <= d_req_addr;
            r_wdata  <= d_req_wdata;
`ifndef L1_MAU_ARB_FIXED_PRIO_EN
            r_last_d <= 1'b1;
`endif
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_req_ack) begin
            r_state <= IDLE;
            r_val   <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_val   <= 1'b0;
        end
      endcase
    end
  end

  // Acks are combinational off the MAU ack; data is zeroed outside the ack cycle
  assign w_ack_i = (r_state == BUSY_I) && mem_req_ack;
  assign w_ack_d = (r_state == BUSY_D) && mem_req_ack;

  assign i_req_ack     = w_ack_i;
  assign d_req_ack     = w_ack_d;
  assign i_ack_data    = w_ack_i ? mem_ack_data : '0;
  assign d_ack_data    = w_ack_d ? mem_ack_data : '0;
  assign mem_req_val   = r_val;
  assign mem_req_cop   = r_cop;
  assign mem_req_addr  = r_addr;
  assign mem_req_wdata = r_wdata;

`ifndef SYNTHESIS
  logic w_i_wait;
  logic w_d_wait;
  assign w_i_wait = i_req_val && (r_state != BUSY_I) && !w_grant_i;
  assign w_d_wait = d_req_val && (r_state != BUSY_D) && !w_grant_d;

  a_ack_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_req_ack && d_req_ack));
  a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (mem_req_val && !mem_req_ack) |=> (mem_req_val && $stable(mem_req_cop) &&
      $stable(mem_req_addr) && $stable(mem_req_wdata)));
  a_i_hold: assert property (@(posedge clk) disable iff (!rst_n) w_i_wait |=> i_req_val);
  a_d_hold: assert property (@(posedge clk) disable iff (!rst_n) w_d_wait |=> d_req_val);
`endif

endmodule

// File: tb/tb_l1_mau_arb.sv
// Randomized and directed checks of l1_mau_arb against a transaction-level arbitration model.
module tb_l1_mau_arb;
  localparam int AW = 32;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req_val;
  logic [AW-1:0] i_req_addr;
  logic          i_req_ack;
  logic [LW-1:0] i_ack_data;
  logic          d_req_val;
  logic          d_req_cop;
  logic [AW-1:0] d_req_addr;
  logic [LW-1:0] d_req_wdata;
  logic          d_req_ack;
  logic [LW-1:0] d_ack_data;
  logic          mem_req_val;
  logic          mem_req_cop;
  logic [AW-1:0] mem_req_addr;
  logic [LW-1:0] mem_req_wdata;
  logic          mem_req_ack;
  logic [LW-1:0] mem_ack_data;

  l1_mau_arb #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_val(i_req_val), .i_req_addr(i_req_addr), .i_req_ack(i_req_ack), .i_ack_data(i_ack_data),
    .d_req_val(d_req_val), .d_req_cop(d_req_cop), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_req_ack(d_req_ack), .d_ack_data(d_ack_data),
    .mem_req_val(mem_req_val), .mem_req_cop(mem_req_cop), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_ack(mem_req_ack), .mem_ack_data(mem_ack_data)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: who owns the memory port, who won last, and the granted request
  int            m_own;     // 0 none, 1 I-side, 2 D-side
  bit            m_last_d;
  logic          m_cop;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;

  // Values seen at the last sample point
  logic          s_mem_val, s_i_ack, s_d_ack;
  logic [AW-1:0] s_addr;
  logic [LW-1:0] s_i_data, s_d_data;

  function automatic int winner(input bit iv, input bit dv, input bit last_d);
`ifdef L1_MAU_ARB_FIXED_PRIO_EN
    if (dv) return 2;
    if (iv) return 1;
    return 0;
`else
    if (iv && dv) return last_d ? 1 : 2;
    if (iv) return 1;
    if (dv) return 2;
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_own = 0; m_last_d = 1'b1; m_cop = 1'b0; m_addr = '0; m_wdata = '0;
  endtask

  task automatic check_outputs();
    logic ei, ed;
    if (!rst_n) begin
      chk("rst_mem_val", mem_req_val, 0);
      chk("rst_mem_cop", mem_req_cop, 0);
      chk("rst_mem_addr", mem_req_addr, 0);
      chk("rst_mem_wdata", mem_req_wdata, 0);
      chk("rst_i_ack", i_req_ack, 0);
      chk("rst_d_ack", d_req_ack, 0);
      return;
    end
    ei = (m_own == 1) && mem_req_ack;
    ed = (m_own == 2) && mem_req_ack;
    chk("mem_val", mem_req_val, (m_own != 0));
    if (m_own != 0) begin
      chk("mem_addr", mem_req_addr, m_addr);
      chk("mem_cop", mem_req_cop, m_cop);
      chk("mem_wdata", mem_req_wdata, m_wdata);
    end
    chk("i_ack", i_req_ack, ei);
    chk("d_ack", d_req_ack, ed);
    chk("i_data", i_ack_data, ei ? mem_ack_data : '0);
    chk("d_data", d_ack_data, ed ? mem_ack_data : '0);
  endtask

  task automatic model_next();
    int w;
    if (!rst_n) begin
      model_reset();
    end else if (m_own != 0) begin
      if (mem_req_ack) m_own = 0;
    end else begin
      w = winner(i_req_val, d_req_val, m_last_d);
      if (w == 1) begin
        m_own = 1; m_last_d = 1'b0; m_cop = 1'b0; m_addr = i_req_addr; m_wdata = '0;
      end else if (w == 2) begin
        m_own = 2; m_last_d = 1'b1; m_cop = d_req_cop; m_addr = d_req_addr; m_wdata = d_req_wdata;
      end
    end
  endtask

  // Inputs are driven 1 unit after posedge; outputs are sampled at negedge
  task automatic step();
    @(negedge clk);
    s_mem_val = mem_req_val; s_i_ack = i_req_ack; s_d_ack = d_req_ack;
    s_addr = mem_req_addr; s_i_data = i_ack_data; s_d_data = d_ack_data;
    check_outputs();
    model_next();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [LW-1:0] dead_beef;
    logic [LW-1:0] a5_line;
    int            order[$];
    int            exp_order[6];
    int            i_cnt, d_cnt, vcnt, last_ack_c;
    bit            prev_val;

    dead_beef = {4{32'hDEAD_BEEF}};
    a5_line   = {16{8'hA5}};
    rst_n = 1'b0;
    i_req_val = 0; i_req_addr = '0; d_req_val = 0; d_req_cop = 0; d_req_addr = '0;
    d_req_wdata = '0; mem_req_ack = 0; mem_ack_data = '0;
    model_reset();
    @(posedge clk); #1;
    step(); step();
    rst_n = 1'b1;
    step();

    // I-only read: request at N, ack at N+4
    i_req_val = 1; i_req_addr = 32'h0000_1040;
    step();
    chk("ionly_val", mem_req_val, 1);
    chk("ionly_addr", mem_req_addr, 32'h0000_1040);
    chk("ionly_cop", mem_req_cop, 0);
    step(); step(); step();
    mem_req_ack = 1; mem_ack_data = dead_beef;
    step();
    chk("ionly_ack", s_i_ack, 1);
    chk("ionly_data", s_i_data, dead_beef);
    i_req_val = 0; mem_req_ack = 0; mem_ack_data = '0;
    step();
    chk("ionly_val_drop", s_mem_val, 0);

    // D-side write-back
    d_req_val = 1; d_req_cop = 1; d_req_addr = 32'h0000_2000; d_req_wdata = a5_line;
    step();
    for (int k = 0; k < 3; k++) begin
      chk("dwr_cop", mem_req_cop, 1);
      chk("dwr_wdata", mem_req_wdata, a5_line);
      step();
    end
    mem_req_ack = 1; mem_ack_data = rnd_line();
    step();
    chk("dwr_ack", s_d_ack, 1);
    chk("dwr_i_ack", s_i_ack, 0);
    d_req_val = 0; mem_req_ack = 0;
    step();
    chk("dwr_ack_pulse", s_d_ack, 0);

    // Reset while D-side transaction is outstanding
    d_req_val = 1; d_req_cop = 0; d_req_addr = 32'h0000_3000;
    step(); step();
    rst_n = 0; d_req_val = 0;
    #1;
    chk("rst_async_val", mem_req_val, 0);
    step();
    rst_n = 1;
    step();
    mem_req_ack = 1;
    step();
    chk("stale_d_ack", s_d_ack, 0);
    chk("stale_i_ack", s_i_ack, 0);
    mem_req_ack = 0;
    step();

    // Spurious ack in IDLE
    mem_req_ack = 1; mem_ack_data = rnd_line();
    step();
    chk("spur_i_ack", s_i_ack, 0);
    chk("spur_d_ack", s_d_ack, 0);
    mem_req_ack = 0;
    step();
    chk("spur_idle", s_mem_val, 0);

    // Tie after reset: three back-to-back requests per side
`ifdef L1_MAU_ARB_FIXED_PRIO_EN
    exp_order = '{2, 2, 2, 1, 1, 1};
`else
    exp_order = '{1, 2, 1, 2, 1, 2};
`endif
    i_cnt = 0; d_cnt = 0; vcnt = 0; last_ack_c = -1; prev_val = 0;
    i_req_val = 1; i_req_addr = 32'h1000_0000;
    d_req_val = 1; d_req_cop = 0; d_req_addr = 32'h2000_0000; d_req_wdata = '0;
    for (int c = 0; c < 200 && (i_cnt < 3 || d_cnt < 3); c++) begin
      mem_req_ack = mem_req_val && (vcnt == 2);
      mem_ack_data = rnd_line();
      step();
      if (s_mem_val && !prev_val) begin
        order.push_back(int'(s_addr[31:28]));
        if (last_ack_c >= 0) chk("tie_gap", c - last_ack_c, 2);
      end
      prev_val = s_mem_val;
      vcnt = (s_mem_val && !s_i_ack && !s_d_ack) ? vcnt + 1 : 0;
      if (s_i_ack || s_d_ack) last_ack_c = c;
      if (s_i_ack) begin
        i_cnt++; i_req_val = (i_cnt < 3); i_req_addr = i_req_addr + 32'h10;
      end
      if (s_d_ack) begin
        d_cnt++; d_req_val = (d_cnt < 3); d_req_addr = d_req_addr + 32'h10;
      end
    end
    mem_req_ack = 0; i_req_val = 0; d_req_val = 0;
    chk("tie_count", order.size(), 6);
    for (int k = 0; k < 6 && k < order.size(); k++) chk($sformatf("tie_order%0d", k), order[k], exp_order[k]);
    step();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (m_own == 1) begin
        if (i_req_val && $urandom_range(0, 15) == 0) i_req_val = 0;
      end else if (!(i_req_val && !s_i_ack)) begin
        i_req_val = ($urandom_range(0, 2) != 0);
        i_req_addr = $urandom & 32'hFFFF_FFF0;
      end
      if (m_own == 2) begin
        if (d_req_val && $urandom_range(0, 15) == 0) d_req_val = 0;
      end else if (!(d_req_val && !s_d_ack)) begin
        d_req_val = ($urandom_range(0, 2) != 0);
        d_req_cop = 1'($urandom_range(0, 1));
        d_req_addr = $urandom & 32'hFFFF_FFF0;
        d_req_wdata = rnd_line();
      end
      mem_req_ack = mem_req_val ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      mem_ack_data = rnd_line();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/l1_mau_arb.md
Name: l1_mau_arb

Overview:
- Arbitrates line-fill and write-back traffic from the L1 instruction cache (I-side, read only) and the L1 data cache (D-side, read/write) onto the single shared MAU memory port.
- Sits between both L1 caches' MAU-side ports and the memory access unit.
- Latches the winning request, holds it on the memory port until acknowledged, and routes the acknowledge pulse and line data back to the owner.
- Round-robin arbitration by default.

Parameters:
- ADDR_W, 32, address width (`CORE_ADDR_WIDTH).
- LINE_W, 128, cache line width in bits (`L1_LINE_SIZE).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_req_val  in  1  I-side request valid; held high until i_req_ack.
- i_req_addr  in  ADDR_W  I-side line address; offset bits are zero.
- i_req_ack  out  1  single-cycle acknowledge to the I-side.
- i_ack_data  out  LINE_W  fill data; valid when i_req_ack=1.
- d_req_val  in  1  D-side request valid; held high until d_req_ack.
- d_req_cop  in  1  0=RD, 1=WR.
- d_req_addr  in  ADDR_W  D-side line address.
- d_req_wdata  in  LINE_W  write-back line, used when cop=WR.
- d_req_ack  out  1  single-cycle acknowledge to the D-side.
- d_ack_data  out  LINE_W  fill data; valid when d_req_ack=1 and cop=RD.
- mem_req_val  out  1  request to the MAU.
- mem_req_cop  out  1  0=RD, 1=WR.
- mem_req_addr  out  ADDR_W  request address.
- mem_req_wdata  out  LINE_W  write data.
- mem_req_ack  in  1  single-cycle MAU acknowledge.
- mem_ack_data  in  LINE_W  read data; valid with mem_req_ack.

Behaviour:
- Reset: clk with rst_n asynchronous, active-low.
  - State=IDLE; last_grant=D, so the I-side wins the first tie.
  - mem_req_val=0, mem_req_cop=0, mem_req_addr=0, mem_req_wdata=0.
  - i_req_ack=0, d_req_ack=0.
- State machine: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - Samples i_req_val and d_req_val.
  - Only one valid: grant it.
  - Both valid: grant the side not equal to last_grant.
  - On grant, register addr, cop and wdata (I-side: cop=RD, wdata=0), update last_grant, and go to BUSY_I or BUSY_D.
  - No request: stay in IDLE.
- BUSY_x:
  - mem_req_val=1, driven from the request registers. mem_req_* is stable for the whole transaction.
  - On mem_req_ack=1: assert the owner's ack in the same cycle (combinational).
  - x_ack_data = mem_ack_data in the same cycle. Non-owner ack is 0.
  - mem_req_val stays 1 through the ack cycle; next state is IDLE.
- Latency:
  - Request sampled in IDLE at cycle N gives mem_req_val=1 at N+1.
  - mem_req_ack at cycle M gives the owner's ack at M.
  - IDLE at M+1; the next grant's mem_req_val is earliest at M+2.
  - Requesters still asserting val during their ack cycle are never re-granted from that cycle.
- Ack data outputs:
  - i_ack_data/d_ack_data are forced to 0 when the matching ack is 0 (no X leakage).
  - On a D-side WR, d_ack_data is don't-care and is driven with mem_ack_data.
- Boundary conditions:
  - mem_req_ack while in IDLE: ignored; no requester ack.
  - Requester val drops before grant: no grant (protocol violation, flagged by assertion).
  - Requester val drops after grant: the transaction completes anyway and the ack is still pulsed.
  - Reset mid-transaction: immediate return to IDLE with all outputs at reset values; a stale mem_req_ack after reset is ignored.
  - Back-to-back requests from both sides: strict alternation I, D, I, D...; neither side waits more than one transaction.
- Assertions (synthesis off):
  - i_req_ack and d_req_ack are never both high.
  - mem_req_* is stable while mem_req_val=1 and mem_req_ack=0.

Optional Feature:
- Macro: L1_MAU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, D-side always wins when both are valid in IDLE; last_grant is unused.
- Undefined: round-robin as described above.
- Latency, handshake and reset behaviour are identical in both modes.

Test Plan:
- I-only: i_req_val=1 with addr=0x0000_1040 at N -> mem_req_val=1, addr=0x1040, cop=RD at N+1. MAU acks at N+4 with data=0xDEAD..BEEF -> i_req_ack=1 and i_ack_data matches at N+4. mem_req_val=0 at N+5.
- D write: d_req_val=1, cop=WR, addr=0x2000, wdata=0xA5 pattern -> mem_req_cop=1 and mem_req_wdata=0xA5 pattern held until ack. d_req_ack pulses exactly 1 cycle; i_req_ack stays 0.
- Tie after reset: both valid in the same cycle -> I granted first (addr=I's). After its ack, D granted with mem_req_val at ack+2. Repeat 4 rounds -> grant order I, D, I, D.
- Fixed priority: with L1_MAU_ARB_FIXED_PRIO_EN defined, both sides continuously valid for 3 requests -> D granted all 3 before I.
- Reset mid-operation: rst_n=0 in BUSY_D before ack -> mem_req_val=0 asynchronously. mem_req_ack=1 one cycle after release -> no d_req_ack and no i_req_ack.
- Spurious ack: mem_req_ack=1 in IDLE with no requests -> both acks stay 0 and state remains IDLE.
